// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: memory-stage FSM states,
// the default data-memory base address and the register-index width.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int unsigned BASE_ADDR_DEF = 32'd1024;
    localparam int          REG_IDX_W     = 32'd5;

    // Rebase a byte address onto data memory and drop the byte offset.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and
// leaves the data fields untouched; the read value only moves for loads.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bubble,
    input  logic                 WB_en_in,
    input  logic                 MEM_R_EN_in,
    input  logic [REG_IDX_W-1:0] Dest_in,
    input  logic [31:0]          ALU_result_in,
    input  logic [31:0]          read_data,
    input  logic [31:0]          PC_in,
    output logic                 WB_en,
    output logic                 MEM_R_EN,
    output logic [REG_IDX_W-1:0] Dest,
    output logic [31:0]          ALU_result,
    output logic [31:0]          Mem_read_value,
    output logic [31:0]          PC
);

    // Load a bubble while the stage is frozen, otherwise capture the stage inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_en          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            Dest           <= '0;
            ALU_result     <= 32'd0;
            Mem_read_value <= 32'd0;
            PC             <= 32'd0;
        end else if (bubble) begin
            WB_en    <= 1'b0;
            MEM_R_EN <= 1'b0;
        end else begin
            WB_en      <= WB_en_in;
            MEM_R_EN   <= MEM_R_EN_in;
            Dest       <= Dest_in;
            ALU_result <= ALU_result_in;
            PC         <= PC_in;
            if (MEM_R_EN_in) begin
                Mem_read_value <= read_data;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: sequences loads/stores against a fixed-latency
// single-port SRAM, freezes upstream while an access is outstanding and
// drives the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int          WAIT_CYCLES = 32'd4,
    parameter int          ADDR_W      = 32'd16,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WB_en_in,
    input  logic                 MEM_R_EN_in,
    input  logic                 MEM_W_EN_in,
    input  logic [31:0]          ALU_result_in,
    input  logic [31:0]          Val_Rm,
    input  logic [REG_IDX_W-1:0] Dest_in,
    input  logic [31:0]          PC_in,
    output logic                 freeze,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata,
    output logic                 WB_en,
    output logic                 MEM_R_EN,
    output logic [REG_IDX_W-1:0] Dest,
    output logic [31:0]          ALU_result,
    output logic [31:0]          Mem_read_value,
    output logic [31:0]          PC
);

    localparam int CNT_W = (WAIT_CYCLES > 32'd1) ? $clog2(WAIT_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 32'd1);

    mem_state_t         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        rbuf_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic               we_r;
    logic               req_s;

    assign req_s = MEM_R_EN_in | MEM_W_EN_in;

    // Stall upstream until the access reaches DONE; never stall while in reset.
    assign freeze = req_s & (state_r != DONE) & ~rst;

    // SRAM strobes decode straight from the state register so reset drops them at once.
    assign sram_en    = (state_r == WAIT);
    assign sram_we    = (state_r == WAIT) & we_r;
    assign sram_addr  = addr_r;
    assign sram_wdata = wdata_r;

    // Access sequencer: latch address/data on entry, count the latency, capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            rbuf_r  <= 32'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        state_r <= WAIT;
                        cnt_r   <= '0;
                        addr_r  <= ADDR_W'(word_index(ALU_result_in, 32'(BASE_ADDR)));
                        wdata_r <= Val_Rm;
                        // A load wins when both requests are raised.
                        we_r    <= MEM_W_EN_in & ~MEM_R_EN_in;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(32'd1);
                    if (cnt_r == CNT_LAST) begin
                        rbuf_r  <= sram_rdata;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .bubble         (freeze),
        .WB_en_in       (WB_en_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .Dest_in        (Dest_in),
        .ALU_result_in  (ALU_result_in),
        .read_data      (rbuf_r),
        .PC_in          (PC_in),
        .WB_en          (WB_en),
        .MEM_R_EN       (MEM_R_EN),
        .Dest           (Dest),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .PC             (PC)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at WAIT_CYCLES=4, one at 1,
// each with a small SRAM model; MEM/WB results checked from a scoreboard.
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mrv;
        logic [31:0] pc;
    } wb_t;

    wb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  pc_hits = 0;
    int  en_first = 0;
    int  en_last = 0;
    bit  dsel = 1'b0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Cycle counter used to time SRAM strobe edges.
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A (WAIT_CYCLES = 4) signals
    logic        a_wb_i, a_mr_i, a_mw_i;
    logic [31:0] a_alu_i, a_vrm, a_pc_i;
    logic [4:0]  a_dest_i;
    logic        a_fz, a_en, a_we, a_wb, a_mr;
    logic [15:0] a_addr;
    logic [31:0] a_wdata, a_rdata, a_alu, a_mrv, a_pc;
    logic [4:0]  a_dest;
    // DUT B (WAIT_CYCLES = 1) signals
    logic        b_wb_i, b_mr_i, b_mw_i;
    logic [31:0] b_alu_i, b_vrm, b_pc_i;
    logic [4:0]  b_dest_i;
    logic        b_fz, b_en, b_we, b_wb, b_mr;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_rdata, b_alu, b_mrv, b_pc;
    logic [4:0]  b_dest;

    mem_stage #(.WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .WB_en_in(a_wb_i), .MEM_R_EN_in(a_mr_i), .MEM_W_EN_in(a_mw_i),
        .ALU_result_in(a_alu_i), .Val_Rm(a_vrm), .Dest_in(a_dest_i), .PC_in(a_pc_i),
        .freeze(a_fz), .sram_en(a_en), .sram_we(a_we), .sram_addr(a_addr), .sram_wdata(a_wdata),
        .sram_rdata(a_rdata), .WB_en(a_wb), .MEM_R_EN(a_mr), .Dest(a_dest), .ALU_result(a_alu),
        .Mem_read_value(a_mrv), .PC(a_pc)
    );

    mem_stage #(.WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .WB_en_in(b_wb_i), .MEM_R_EN_in(b_mr_i), .MEM_W_EN_in(b_mw_i),
        .ALU_result_in(b_alu_i), .Val_Rm(b_vrm), .Dest_in(b_dest_i), .PC_in(b_pc_i),
        .freeze(b_fz), .sram_en(b_en), .sram_we(b_we), .sram_addr(b_addr), .sram_wdata(b_wdata),
        .sram_rdata(b_rdata), .WB_en(b_wb), .MEM_R_EN(b_mr), .Dest(b_dest), .ALU_result(b_alu),
        .Mem_read_value(b_mrv), .PC(b_pc)
    );

    // Unwritten SRAM words read back as a per-address pattern.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {16'hA000, a};
    endfunction

    bit [31:0] a_mem [65536];
    bit [31:0] b_mem [65536];
    // SRAM models: write while strobed, read data always valid.
    always @(posedge clk) if (a_en && a_we) a_mem[a_addr] <= a_wdata ^ pat(a_addr);
    always @(posedge clk) if (b_en && b_we) b_mem[b_addr] <= b_wdata ^ pat(b_addr);
    assign a_rdata = a_mem[a_addr] ^ pat(a_addr);
    assign b_rdata = b_mem[b_addr] ^ pat(b_addr);

    // Count MEM/WB write-backs of the frozen instruction's PC.
    always @(negedge clk) if (!rst && a_wb && a_pc == 32'h0000_0100) pc_hits <= pc_hits + 1;

    // Observed-signal mux for whichever DUT a step targets.
    logic        m_fz, m_en, m_we, m_wb, m_mr;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_alu, m_mrv, m_pc;
    logic [4:0]  m_dest;
    assign m_fz    = dsel ? b_fz    : a_fz;
    assign m_en    = dsel ? b_en    : a_en;
    assign m_we    = dsel ? b_we    : a_we;
    assign m_wb    = dsel ? b_wb    : a_wb;
    assign m_mr    = dsel ? b_mr    : a_mr;
    assign m_addr  = dsel ? b_addr  : a_addr;
    assign m_wdata = dsel ? b_wdata : a_wdata;
    assign m_alu   = dsel ? b_alu   : a_alu;
    assign m_mrv   = dsel ? b_mrv   : a_mrv;
    assign m_pc    = dsel ? b_pc    : a_pc;
    assign m_dest  = dsel ? b_dest  : a_dest;

    // Reference memory and last-load value per DUT.
    bit [31:0] mdl_mem [2][65536];
    bit        mdl_wr  [2][65536];
    logic [31:0] mdl_mrv [2];

    function automatic logic [31:0] mdl_rd(input bit s, input logic [15:0] a);
        return mdl_wr[s][a] ? mdl_mem[s][a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic wb, r, w, input logic [31:0] alu, wd,
                         input logic [4:0] dest, input logic [31:0] pc);
        if (sel) begin
            b_wb_i = wb; b_mr_i = r; b_mw_i = w; b_alu_i = alu; b_vrm = wd; b_dest_i = dest; b_pc_i = pc;
        end else begin
            a_wb_i = wb; a_mr_i = r; a_mw_i = w; a_alu_i = alu; a_vrm = wd; a_dest_i = dest; a_pc_i = pc;
        end
    endtask

    // Issue one instruction at a negedge, follow it through the stage, check MEM/WB.
    task automatic issue(input bit sel, input logic wb, r, w, input logic [31:0] alu, wd,
                         input logic [4:0] dest, input logic [31:0] pc,
                         input int exp_occ, exp_en, exp_we);
        wb_t e, got;
        logic [15:0] ea;
        int occ, nen, nwe;
        ea = 16'((alu - 32'd1024) >> 2);
        dsel = sel;
        drive(sel, wb, r, w, alu, wd, dest, pc);
        if (r) mdl_mrv[sel] = mdl_rd(sel, ea);
        else if (w) begin
            mdl_mem[sel][ea] = wd;
            mdl_wr[sel][ea] = 1'b1;
        end
        e = '{wb, r, dest, alu, mdl_mrv[sel], pc};
        sb_q.push_back(e);
        occ = 0; nen = 0; nwe = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            occ++;
            if (m_en) begin
                nen++;
                if (nen == 1) en_first = cyc;
                en_last = cyc;
                chk("sram_addr", 32'(m_addr), 32'(ea));
            end
            if (m_we) begin
                nwe++;
                chk("sram_wdata", m_wdata, wd);
            end
            if (k > 0) chk("wb_bubble", 32'(m_wb), 32'd0);
            if (!m_fz) break;
            @(negedge clk); #1;
        end
        chk("freeze_released", 32'(m_fz), 32'd0);
        chk("occupancy", 32'(occ), 32'(exp_occ));
        chk("en_cycles", 32'(nen), 32'(exp_en));
        chk("we_cycles", 32'(nwe), 32'(exp_we));
        @(negedge clk);
        got = '{m_wb, m_mr, m_dest, m_alu, m_mrv, m_pc};
        e = sb_q.pop_front();
        chk("WB_en", 32'(got.wb), 32'(e.wb));
        chk("MEM_R_EN", 32'(got.mr), 32'(e.mr));
        chk("Dest", 32'(got.dest), 32'(e.dest));
        chk("ALU_result", got.alu, e.alu);
        chk("Mem_read_value", got.mrv, e.mrv);
        chk("PC", got.pc, e.pc);
        drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    endtask

    initial begin
        int l1;
        rst = 1'b1;
        mdl_mrv[0] = 32'd0;
        mdl_mrv[1] = 32'd0;
        dsel = 1'b0;
        // Reset held with a load request present on A.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 5'd4, 32'h0000_0050);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk); #1;
        chk("rst_WB_en", 32'(a_wb), 32'd0);
        chk("rst_MEM_R_EN", 32'(a_mr), 32'd0);
        chk("rst_Dest", 32'(a_dest), 32'd0);
        chk("rst_ALU_result", a_alu, 32'd0);
        chk("rst_Mem_read_value", a_mrv, 32'd0);
        chk("rst_PC", a_pc, 32'd0);
        chk("rst_freeze", 32'(a_fz), 32'd0);
        chk("rst_sram_en", 32'(a_en), 32'd0);
        chk("rst_sram_we", 32'(a_we), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU pass-through.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'd0, 5'd5, 32'h0000_0010, 1, 0, 0);
        // Store then load at 1028 (word 1).
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 5'd3, 32'h0000_0014, 6, 4, 4);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 5'd7, 32'h0000_0100, 6, 4, 0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'd0, 5'd1, 32'h0000_0018, 1, 0, 0);
        #1;
        chk("pc_once", 32'(pc_hits), 32'd1);

        // Back-to-back loads: strobe gap of exactly the DONE and IDLE cycles.
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 5'd8, 32'h0000_0020, 6, 4, 0);
        l1 = en_last;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 5'd9, 32'h0000_0024, 6, 4, 0);
        chk("b2b_gap", 32'(en_first - (l1 + 1)), 32'd2);

        // Reset mid-WAIT aborts a store that would write back.
        dsel = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd1040, 32'h5555_AAAA, 5'd11, 32'h0000_0040);
        @(negedge clk); @(negedge clk); #1;
        chk("midwait_sram_en", 32'(a_en), 32'd1);
        chk("midwait_sram_we", 32'(a_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sram_en", 32'(a_en), 32'd0);
        chk("abort_sram_we", 32'(a_we), 32'd0);
        chk("abort_freeze", 32'(a_fz), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        mdl_mrv[0] = 32'd0;
        mdl_mrv[1] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_WB_en", 32'(a_wb), 32'd0);
        chk("abort_Mem_read_value", a_mrv, 32'd0);
        @(negedge clk); #1;
        chk("abort_WB_en_later", 32'(a_wb), 32'd0);

        // WAIT_CYCLES = 1 with both requests raised: load semantics, no write.
        issue(1'b1, 1'b1, 1'b1, 1'b1, 32'd1056, 32'h1234_5678, 5'd10, 32'h0000_0030, 3, 1, 0);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'd1056, 32'd0, 5'd12, 32'h0000_0034, 3, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between EXE and WB. Sequences loads and stores against an external single-port, fixed-latency SRAM; freezes upstream stages while an access is outstanding; and drives the MEM/WB pipeline register that feeds the write-back stage its WB enable, read-select, ALU result, memory read value, destination register and PC.

## Interface

- `WAIT_CYCLES`, default 4: SRAM access latency in cycles. Legal range is ≥1.
- `ADDR_W`, default 16: SRAM word-address width.
- `BASE_ADDR`, default 1024: byte address of data memory word 0.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `WB_en_in` in 1: EXE/MEM write-back enable.
- `MEM_R_EN_in` in 1: load request.
- `MEM_W_EN_in` in 1: store request.
- `ALU_result_in` in 32: effective byte address, or ALU value.
- `Val_Rm` in 32: store data.
- `Dest_in` in 5: destination register.
- `PC_in` in 32: instruction PC.
- `freeze` out 1: stalls IF/ID/EXE and their pipeline registers.
- `sram_en` out 1: SRAM access strobe.
- `sram_we` out 1: SRAM write enable.
- `sram_addr` out `ADDR_W`: SRAM word address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid in the last wait cycle.
- `WB_en`, `MEM_R_EN`, `Dest`, `ALU_result`, `Mem_read_value`, `PC` out (1/1/5/32/32/32): MEM/WB register outputs to WB.

## Operation

- A request is `MEM_R_EN_in | MEM_W_EN_in`. If both are set, the load wins and `sram_we` = 0.
- Address: `sram_addr = (ALU_result_in - BASE_ADDR) >> 2`, truncated to `ADDR_W`. Bits [1:0] are ignored, so accesses are word-aligned only.
- FSM states:
  - IDLE: on a request, go to WAIT with the counter at 0. Otherwise stay in IDLE.
  - WAIT: the counter increments each cycle. When counter = `WAIT_CYCLES`-1, capture `sram_rdata` into the read buffer and go to DONE.
  - DONE: go to IDLE unconditionally.
- `freeze` = request & (state ≠ DONE). It is combinational.
- `sram_en` is high in WAIT only. `sram_we` is high in WAIT only, and only for stores. `sram_addr` and `sram_wdata` are held stable throughout WAIT.
- MEM/WB register update on every rising edge:
  - While `freeze` = 1, load a bubble: `WB_en` = 0, `MEM_R_EN` = 0, other fields unchanged.
  - Otherwise, load the stage inputs.
  - `Mem_read_value` takes the read buffer for loads, and is unchanged for all other instructions.
- A non-memory instruction passes through in 1 cycle, with no FSM activity.

## Timing

- Reset clears everything to 0: all MEM/WB outputs, the state (IDLE), the counter, the read buffer, `freeze`, `sram_en` and `sram_we`. This takes effect immediately and asynchronously.
- Memory instruction entering in cycle 0:
  - Cycle 0 is IDLE with `freeze` = 1.
  - Cycles 1..W are WAIT, with `freeze` = 1 and `sram_en` = 1.
  - Cycle W+1 is DONE with `freeze` = 0.
  - MEM/WB outputs update at the end of cycle W+1. Stage occupancy is W+2 cycles.
- Back-to-back memory instructions: the second enters in the cycle after DONE, which is IDLE. There is no dead cycle beyond the DONE cycle.
- Reset asserted mid-WAIT aborts the access. The SRAM strobes drop asynchronously, and no partial result reaches WB.
- `WAIT_CYCLES` = 1: exactly one WAIT cycle, and capture happens in it.

## Structure

- Shared package `mips_pkg` holds:
  - the `mem_state_t` enum (IDLE, WAIT, DONE);
  - the `BASE_ADDR` default;
  - the register-index width constant (5).
- Sub-module `mem_wb_reg` implements the MEM/WB register with a bubble input. The FSM, counter and SRAM drive stay in `mem_stage`.

## Test plan

- **Reset:** hold `rst` = 1 → all outputs 0 and `freeze` = 0. Assert `rst` mid-WAIT → `sram_en` = 0 immediately, and `WB_en` = 0 after release.
- **ALU pass-through:** `WB_en_in` = 1, `ALU_result_in` = 0x0000_002A, `Dest_in` = 5, no memory request → next edge gives `ALU_result` = 0x2A, `Dest` = 5, `WB_en` = 1, and `freeze` stays 0.
- **Store then load, W = 4:**
  - Store with `ALU_result_in` = 1028 and `Val_Rm` = 0xDEAD_BEEF → `sram_addr` = 1 and `sram_we` = 1 for 4 cycles, `freeze` = 1 for 5 cycles, and `WB_en` = 0 throughout the store.
  - Following load from 1028 → `Mem_read_value` = 0xDEAD_BEEF and `MEM_R_EN` = 1 after 6 cycles.
- **Freeze bubble:** during a load, confirm `WB_en` = 0 on every freeze edge, and that the PC of the frozen instruction reaches WB exactly once.
- **Back-to-back loads:** loads from 1024 and 1032 → the second `sram_en` rises exactly 2 cycles after the first `sram_en` falls.
- **`WAIT_CYCLES` = 1 with read and write both asserted** → a single WAIT cycle, `sram_we` = 0, load semantics, and 3-cycle occupancy.
